// File: rtl/axil_ext_pkg.sv
// Shared constants for the external AXI-lite slave port: default widths, window base and clog2.
package axil_ext_pkg;

   localparam int unsigned AXIL_ADDR_W = 32;
   localparam int unsigned AXIL_DATA_W = 32;

   // Base of the external register window in the SoC memory map.
   localparam logic [AXIL_ADDR_W-1:0] EXT_WIN_BASE = 32'h0300_0000;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axil_ext_wr_collect.sv
// AW/W one-entry holding buffers for an AXI-lite write slave; emits a commit strobe and
// owns the held write response.
module axil_ext_wr_collect
   import axil_ext_pkg::*;
#(
   parameter int unsigned AddrW = AXIL_ADDR_W,
   parameter int unsigned DataW = AXIL_DATA_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               awvalid_i,
   output logic               awready_o,
   input  logic [AddrW-1:0]   awaddr_i,
   input  logic               wvalid_i,
   output logic               wready_o,
   input  logic [DataW-1:0]   wdata_i,
   input  logic [DataW/8-1:0] wstrb_i,
   output logic               bvalid_o,
   input  logic               bready_i,
   output logic               cmt_o,
   output logic [AddrW-1:0]   cmt_addr_o,
   output logic [DataW-1:0]   cmt_data_o,
   output logic [DataW/8-1:0] cmt_strb_o
);

   logic               aw_full_q, aw_full_d;
   logic               w_full_q, w_full_d;
   logic               bvalid_q, bvalid_d;
   logic [AddrW-1:0]   awaddr_q, awaddr_d;
   logic [DataW-1:0]   wdata_q, wdata_d;
   logic [DataW/8-1:0] wstrb_q, wstrb_d;

   assign awready_o  = en_i && !aw_full_q && !bvalid_q;
   assign wready_o   = en_i && !w_full_q && !bvalid_q;
   assign cmt_o      = aw_full_q && w_full_q;
   assign cmt_addr_o = awaddr_q;
   assign cmt_data_o = wdata_q;
   assign cmt_strb_o = wstrb_q;
   assign bvalid_o   = bvalid_q;

   always_comb begin
      aw_full_d = aw_full_q;
      w_full_d  = w_full_q;
      bvalid_d  = bvalid_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      if (awvalid_i && awready_o) begin
         aw_full_d = 1'b1;
         awaddr_d  = awaddr_i;
      end
      if (wvalid_i && wready_o) begin
         w_full_d = 1'b1;
         wdata_d  = wdata_i;
         wstrb_d  = wstrb_i;
      end
      // Fills need !bvalid, so a commit can never overlap a pending response.
      if (cmt_o) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
      end
      if (bvalid_q && bready_i) bvalid_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         bvalid_q  <= bvalid_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

endmodule

// File: rtl/axil_ext_regbank.sv
// AXI-lite register bank on the external port with parallel register export.
// Define AXIL_EXT_REGBANK_CYCCNT_EN to map a read-only cycle counter just above the window.
module axil_ext_regbank
   import axil_ext_pkg::*;
#(
   parameter int unsigned        ADDR_W    = AXIL_ADDR_W,
   parameter int unsigned        DATA_W    = AXIL_DATA_W,
   parameter int unsigned        NUM_REGS  = 8,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = EXT_WIN_BASE
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ext_awvalid,
   output logic                       ext_awready,
   input  logic [ADDR_W-1:0]          ext_awaddr,
   input  logic                       ext_wvalid,
   output logic                       ext_wready,
   input  logic [DATA_W-1:0]          ext_wdata,
   input  logic [DATA_W/8-1:0]        ext_wstrb,
   output logic                       ext_bvalid,
   input  logic                       ext_bready,
   input  logic                       ext_arvalid,
   output logic                       ext_arready,
   input  logic [ADDR_W-1:0]          ext_araddr,
   output logic                       ext_rvalid,
   input  logic                       ext_rready,
   output logic [DATA_W-1:0]          ext_rdata,
   output logic [NUM_REGS*DATA_W-1:0] reg_out
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFFS   = clog2(STRB_W);
   localparam int unsigned IDX_W  = clog2(NUM_REGS);
`ifdef AXIL_EXT_REGBANK_CYCCNT_EN
   localparam int unsigned DEC_W  = IDX_W + 1;
`else
   localparam int unsigned DEC_W  = IDX_W;
`endif
   localparam int unsigned TAG_SH = OFFS + DEC_W;

   logic                live_q;
   logic                en;
   logic                cmt;
   logic [ADDR_W-1:0]   cmt_addr;
   logic [DATA_W-1:0]   cmt_data;
   logic [STRB_W-1:0]   cmt_strb;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic                rvalid_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   rd_val;
   logic [DEC_W-1:0]    wr_idx, rd_idx;
   logic [IDX_W-1:0]    wr_reg, rd_reg;
   logic                wr_in_bank;

   function automatic logic dec_hit(input logic [ADDR_W-1:0] a);
      return (a >> TAG_SH) == (BASE_ADDR >> TAG_SH);
   endfunction

   // Ready is held off until the first clock after reset is released.
   assign en = resetn && live_q;

   axil_ext_wr_collect #(
      .AddrW (ADDR_W),
      .DataW (DATA_W)
   ) u_wr_collect (
      .clk_i      (clk),
      .rst_ni     (resetn),
      .en_i       (en),
      .awvalid_i  (ext_awvalid),
      .awready_o  (ext_awready),
      .awaddr_i   (ext_awaddr),
      .wvalid_i   (ext_wvalid),
      .wready_o   (ext_wready),
      .wdata_i    (ext_wdata),
      .wstrb_i    (ext_wstrb),
      .bvalid_o   (ext_bvalid),
      .bready_i   (ext_bready),
      .cmt_o      (cmt),
      .cmt_addr_o (cmt_addr),
      .cmt_data_o (cmt_data),
      .cmt_strb_o (cmt_strb)
   );

   assign wr_idx = cmt_addr[OFFS +: DEC_W];
   assign rd_idx = ext_araddr[OFFS +: DEC_W];
   assign wr_reg = wr_idx[IDX_W-1:0];
   assign rd_reg = rd_idx[IDX_W-1:0];

`ifdef AXIL_EXT_REGBANK_CYCCNT_EN
   logic [DATA_W-1:0] cyc_q;

   assign wr_in_bank = !wr_idx[IDX_W];

   always_comb begin
      rd_val = '0;
      if (dec_hit(ext_araddr)) begin
         if (!rd_idx[IDX_W])   rd_val = regs_q[rd_reg];
         else if (rd_reg == '0) rd_val = cyc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) cyc_q <= '0;
      else         cyc_q <= cyc_q + DATA_W'(1);
   end
`else
   assign wr_in_bank = 1'b1;

   always_comb begin
      rd_val = '0;
      if (dec_hit(ext_araddr)) rd_val = regs_q[rd_reg];
   end
`endif

   always_comb begin
      regs_d = regs_q;
      if (cmt && dec_hit(cmt_addr) && wr_in_bank) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (cmt_strb[k]) regs_d[wr_reg][8*k +: 8] = cmt_data[8*k +: 8];
         end
      end
   end

   assign ext_arready = en && !rvalid_q;
   assign ext_rvalid  = rvalid_q;
   assign ext_rdata   = rdata_q;

   // Read samples regs_q, so a same-edge commit returns the pre-write value.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         live_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         regs_q   <= '{default: '0};
      end else begin
         live_q <= 1'b1;
         regs_q <= regs_d;
         if (ext_arvalid && ext_arready) begin
            rdata_q  <= rd_val;
            rvalid_q <= 1'b1;
         end else if (rvalid_q && ext_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign reg_out[i*DATA_W +: DATA_W] = regs_q[i];
   end

endmodule

// File: tb/tb_axil_ext_regbank.sv
// Self-checking bench for axil_ext_regbank: hand-timed sequences, a vector table and
// randomized traffic against an address-range reference model.
module tb_axil_ext_regbank;

   localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef AXIL_EXT_REGBANK_CYCCNT_EN
   localparam logic [31:0] WIN = 32'd64;
`else
   localparam logic [31:0] WIN = 32'd32;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  awaddr, araddr, wdata, rdata;
   logic [3:0]   wstrb;
   logic [255:0] reg_out;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   logic [31:0] mdl [8];

   axil_ext_regbank dut (
      .clk         (clk),
      .resetn      (resetn),
      .ext_awvalid (awvalid),
      .ext_awready (awready),
      .ext_awaddr  (awaddr),
      .ext_wvalid  (wvalid),
      .ext_wready  (wready),
      .ext_wdata   (wdata),
      .ext_wstrb   (wstrb),
      .ext_bvalid  (bvalid),
      .ext_bready  (bready),
      .ext_arvalid (arvalid),
      .ext_arready (arready),
      .ext_araddr  (araddr),
      .ext_rvalid  (rvalid),
      .ext_rready  (rready),
      .ext_rdata   (rdata),
      .reg_out     (reg_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic fail_to(input string nm);
      n_chk++;
      $display("FAIL %s: got no handshake expected one within 32 cycles", nm);
   endtask

   // Reference model: plain byte-address window arithmetic.
   function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] s);
      int unsigned idx;
      if (a >= BASE && a < BASE + WIN) begin
         idx = (a - BASE) / 4;
         if (idx < 8) begin
            for (int k = 0; k < 4; k++) if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
         end
      end
   endfunction

   function automatic void mdl_read(input logic [31:0] a, output logic [31:0] d,
                                    output bit ok);
      int unsigned idx;
      d  = '0;
      ok = 1'b1;
      if (a >= BASE && a < BASE + WIN) begin
         idx = (a - BASE) / 4;
         if (idx < 8)       d = mdl[idx];
         else if (idx == 8) ok = 1'b0;
      end
   endfunction

   task automatic take_b(input string nm);
      bit done = 1'b0;
      int cyc = 0;
      bready = 1'b1;
      while (!done && cyc < 32) begin
         @(negedge clk);
         done = bvalid;
         @(posedge clk); #1;
         cyc++;
      end
      bready = 1'b0;
      if (!done) fail_to(nm);
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bdly);
      bit aw_d = 1'b0, w_d = 1'b0, hs_aw, hs_w;
      int cyc = 0;
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b0;
      while (!(aw_d && w_d) && cyc < 32) begin
         @(negedge clk);
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         @(posedge clk); #1;
         if (hs_aw) begin aw_d = 1'b1; awvalid = 1'b0; end
         if (hs_w)  begin w_d = 1'b1;  wvalid = 1'b0;  end
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(aw_d && w_d)) fail_to("wr_aw_w");
      repeat (bdly) begin @(posedge clk); #1; end
      take_b("wr_b");
      mdl_write(a, d, s);
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
      bit done = 1'b0;
      int cyc = 0;
      d = '0;
      arvalid = 1'b1; araddr = a; rready = 1'b1;
      while (!done && cyc < 32) begin
         @(negedge clk);
         done = arready;
         @(posedge clk); #1;
         cyc++;
      end
      arvalid = 1'b0;
      if (!done) fail_to("rd_ar");
      done = 1'b0; cyc = 0;
      while (!done && cyc < 32) begin
         @(negedge clk);
         if (rvalid) begin d = rdata; done = 1'b1; end
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b0;
      if (!done) fail_to("rd_r");
   endtask

   typedef struct {
      logic [31:0] wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] ra;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got, exp, a, c1, c2;
      bit          ok;

      tbl[0] = '{32'h0300_0004, 32'hA5A5_1234, 4'hF, 32'h0300_0004, 32'hA5A5_1234};
      tbl[1] = '{32'h0300_0008, 32'h1122_3344, 4'h5, 32'h0300_0008, 32'h0022_0044};
      tbl[2] = '{32'h0300_0008, 32'hFFFF_FFFF, 4'h2, 32'h0300_0008, 32'h0022_FF44};
      tbl[3] = '{32'h0400_0000, 32'hFFFF_FFFF, 4'hF, 32'h0400_0000, 32'h0000_0000};
      tbl[4] = '{32'h0300_001F, 32'hCAFE_F00D, 4'h8, 32'h0300_001C, 32'hCA00_0000};
      tbl[5] = '{32'h0300_0000, 32'hDEAD_BEEF, 4'h0, 32'h0300_0000, 32'h0000_0000};
      tbl[6] = '{32'h0300_0020, 32'h1234_5678, 4'hF, 32'h0300_0004, 32'hA5A5_1234};

      resetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0;
      rready = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      foreach (mdl[i]) mdl[i] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rel_awready", awready, 1);
      check("rel_wready", wready, 1);
      check("rel_arready", arready, 1);
      check("rel_regout0", reg_out[31:0], 0);
      @(posedge clk); #1;

      // W first, AW three cycles later
      wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'h5;
      @(posedge clk); #1;
      wvalid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("wfirst_wready", wready, 0);
         check("wfirst_awready", awready, 1);
         @(posedge clk); #1;
      end
      awvalid = 1'b1; awaddr = BASE + 8;
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      check("wfirst_bvalid_early", bvalid, 0);
      @(posedge clk); #1;
      mdl_write(BASE + 8, 32'h1122_3344, 4'h5);
      @(negedge clk);
      check("wfirst_bvalid", bvalid, 1);
      check("wfirst_awready_b", awready, 0);
      check("wfirst_wready_b", wready, 0);
      @(posedge clk); #1;
      take_b("wfirst_b");
      axi_read(BASE + 8, got);
      check("wfirst_rd", got, 32'h0022_0044);

      // Same-cycle AW+W, response held with bready low
      awvalid = 1'b1; awaddr = BASE + 16; wvalid = 1'b1; wdata = 32'h0102_0304; wstrb = 4'hF;
      @(negedge clk);
      check("lat_awready_pre", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("lat_bvalid_n", bvalid, 0);
      check("lat_awready_full", awready, 0);
      @(posedge clk); #1;
      mdl_write(BASE + 16, 32'h0102_0304, 4'hF);
      @(negedge clk);
      check("lat_regout4", reg_out[4*32 +: 32], 32'h0102_0304);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_bvalid", bvalid, 1);
         check("hold_awready", awready, 0);
         @(posedge clk); #1;
      end
      bready = 1'b1; awvalid = 1'b1; awaddr = BASE + 20;
      @(negedge clk);
      check("hold_awready_last", awready, 0);
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("hold_bvalid_clr", bvalid, 0);
      check("hold_aw_accept", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      check("hold_aw_full", awready, 0);
      @(posedge clk); #1;
      wvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'h3;
      @(posedge clk); #1;
      wvalid = 1'b0;
      @(posedge clk); #1;
      mdl_write(BASE + 20, 32'hCAFE_0001, 4'h3);
      take_b("hold_b2");
      axi_read(BASE + 20, got);
      check("hold_rd5", got, 32'h0000_0001);

      // Read coincident with commit returns the old value
      axi_write(BASE + 12, 32'h5, 4'hF, 0);
      awvalid = 1'b1; awaddr = BASE + 12; wvalid = 1'b1; wdata = 32'h9; wstrb = 4'hF;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      arvalid = 1'b1; araddr = BASE + 12; rready = 1'b0;
      @(negedge clk);
      check("raw_arready", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      mdl_write(BASE + 12, 32'h9, 4'hF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("raw_rvalid", rvalid, 1);
         check("raw_rdata_old", rdata, 32'h5);
         check("raw_arready_busy", arready, 0);
         @(posedge clk); #1;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
      check("raw_rvalid_clr", rvalid, 0);
      check("raw_rdata_kept", rdata, 32'h5);
      @(posedge clk); #1;
      take_b("raw_b");
      axi_read(BASE + 12, got);
      check("raw_rd_new", got, 32'h9);

      // Reset with a response pending
      axi_write(BASE, 32'h0000_DEAD, 4'hF, 0);
      awvalid = 1'b1; awaddr = BASE + 4; wvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_bvalid_pre", bvalid, 1);
      check("mid_reg0_pre", reg_out[31:0], 32'h0000_DEAD);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      check("mid_bvalid", bvalid, 0);
      check("mid_awready", awready, 0);
      for (int i = 0; i < 8; i++) check("mid_regout", reg_out[i*32 +: 32], 0);
      foreach (mdl[i]) mdl[i] = '0;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_awready_rel", awready, 1);
      @(posedge clk); #1;

      // Vector table
      for (int i = 0; i < 7; i++) begin
         axi_write(tbl[i].wa, tbl[i].wd, tbl[i].ws, i % 3);
         axi_read(tbl[i].ra, got);
         check($sformatf("tbl%0d", i), got, tbl[i].exp);
      end
      check("tbl_regout1", reg_out[63:32], 32'hA5A5_1234);

      // Randomized traffic vs model
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = BASE + $urandom_range(0, 63);
         if ($urandom_range(0, 2) != 0) begin
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
         end else begin
            axi_read(a, got);
            mdl_read(a, exp, ok);
            if (ok) check("rnd_rd", got, exp);
         end
         if (i % 25 == 24) begin
            for (int r = 0; r < 8; r++) check("rnd_regout", reg_out[r*32 +: 32], mdl[r]);
         end
      end

`ifdef AXIL_EXT_REGBANK_CYCCNT_EN
      // Counter reads exactly 10 handshake edges apart
      arvalid = 1'b1; araddr = BASE + 32; rready = 1'b1;
      @(negedge clk);
      check("cyc_arready", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      c1 = rdata;
      repeat (9) @(posedge clk);
      #1;
      arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      c2 = rdata;
      check("cyc_delta", c2 - c1, 32'd10);
      @(posedge clk); #1;
      rready = 1'b0;
      axi_write(BASE + 32, 32'hFFFF_FFFF, 4'hF, 0);
      axi_read(BASE + 36, got);
      check("cyc_above", got, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axil_ext_regbank.md
Name: axil_ext_regbank

Overview:
- Parametrised AXI-lite-style slave register bank for the SoC's external AXI port (ext_aw/w/b/ar/r channel set, no resp fields).
- Replaces the tied-off stub on that port.
- Provides NUM_REGS software-visible R/W registers with byte strobes, decoupled AW/W acceptance and held responses.
- Register contents are exported in parallel to fabric/accelerator logic.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- NUM_REGS, 8, number of R/W registers; power of two, ≥2.
- BASE_ADDR, 32'h0300_0000, window base; must be aligned to the window size.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active low.
- ext_awvalid  in  1  write address valid.
- ext_awready  out  1  write address ready.
- ext_awaddr  in  ADDR_W  write byte address.
- ext_wvalid  in  1  write data valid.
- ext_wready  out  1  write data ready.
- ext_wdata  in  DATA_W  write data.
- ext_wstrb  in  DATA_W/8  byte-lane enables.
- ext_bvalid  out  1  write response valid.
- ext_bready  in  1  write response ready.
- ext_arvalid  in  1  read address valid.
- ext_arready  out  1  read address ready.
- ext_araddr  in  ADDR_W  read byte address.
- ext_rvalid  out  1  read data valid.
- ext_rready  in  1  read data ready.
- ext_rdata  out  DATA_W  read data.
- reg_out  out  NUM_REGS*DATA_W  all registers; register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset: one clock, synchronous, active-low (resetn sampled on posedge clk). While resetn=0:
  - all registers = 0; internal AW/W holding flags cleared;
  - bvalid=0, rvalid=0, rdata=0;
  - awready/wready/arready = 0.
  - Starting the cycle after resetn rises: awready=1, wready=1, arready=1.
- Decode:
  - OFFS = log2(DATA_W/8); IDX_W = log2(NUM_REGS); idx = addr[OFFS +: IDX_W].
  - Hit when addr[ADDR_W-1 : OFFS+IDX_W] == BASE_ADDR[ADDR_W-1 : OFFS+IDX_W].
  - Low offset bits are ignored.
- Write path: AW and W are captured independently into one-entry holding buffers (aw_full, w_full).
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - Channels may arrive in any order or in the same cycle.
  - Commit happens in the cycle where both buffers are full (a buffer filled this edge is seen full next cycle).
  - Commit: for each lane k with wstrb[k]=1, reg[idx] byte k ← wdata byte k. Then clear both flags and set bvalid next edge.
  - A miss or wstrb=0 commits nothing but still produces a response.
  - bvalid holds until bready; it clears on the edge where bvalid&&bready. Ready rises the following cycle.
  - Latency: simultaneous AW+W handshake at edge N → commit at edge N+1 → bvalid high after N+1 → minimum 2 cycles.
- Read path: arready = !rvalid.
  - On the ar handshake edge, rdata ← reg[idx] (0 on miss) and rvalid ← 1.
  - rdata and rvalid are stable until the rready edge, then rvalid=0; rdata keeps its value.
  - One read outstanding at a time; back-to-back reads take 2 cycles each.
- Read/write same register, same edge (ar handshake coincides with commit): rdata returns the pre-write value.
- Read and write channels are fully independent; no ordering between them.
- Reset mid-transaction: pending AW/W and outstanding responses are dropped without completion. Registers return to 0.
- reg_out is registered; it updates on the edge following the commit.

Optional Feature:
- Macro: AXIL_EXT_REGBANK_CYCCNT_EN.
- When defined:
  - A read-only DATA_W-bit free-running cycle counter is added, reset to 0 and incremented every clk, wrapping at 2^DATA_W-1 → 0.
  - It is mapped at the first address above the register window (idx == NUM_REGS). Decode is widened by one index bit, so the hit region doubles; indices above NUM_REGS read 0.
  - Writes to the counter or beyond are discarded but still get bvalid.
  - Reads return the counter value at the ar handshake edge.
- When undefined: no counter, window as above, no extra logic.

Decomposition:
- Package axil_ext_pkg holds shared constants:
  - default AXIL_ADDR_W/AXIL_DATA_W;
  - derived-width function clog2;
  - EXT_WIN_BASE address constant shared with the SoC memory map.
- One sub-module: axil_ext_wr_collect, the AW/W holding buffers plus commit/bvalid logic, reusable by later ext slaves.
- Decode, register array and read path stay in the top.

Test Plan:
- After reset release: AW=0x0300_0004 and W=0xA5A5_1234, strb=0xF in the same cycle, bready=1 → bvalid 2 cycles later. Read 0x0300_0004 → rdata=0xA5A5_1234; reg_out[63:32]=0xA5A5_1234.
- W first (0x11223344, strb=0x5), AW at 0x0300_0008 three cycles later, then read → reg[2]=0x00220044. awready/wready stay low until bready.
- bready held low 5 cycles → bvalid stays 1, awready=0 throughout; a new AW is accepted one cycle after the bready edge.
- Write 0xFFFF_FFFF to 0x0400_0000 (miss) → bvalid still returned, all regs unchanged. Read 0x0400_0000 → rdata=0.
- reg[3]=0x5 and commit of 0x9 to reg[3] coincident with the ar handshake → rdata=0x5; a following read → 0x9. rready low 4 cycles → rdata held, arready=0.
- resetn=0 for 1 cycle while bvalid=1 and reg[0]=0xDEAD → bvalid=0, reg_out=0. With AXIL_EXT_REGBANK_CYCCNT_EN defined: read at idx 8 two reads 10 cycles apart differ by 10.
